// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle radix-2 restoring divider for the EX stage. It
//            accepts one DIV/DIVU request, iterates one quotient bit per
//            clock and returns {remainder, quotient}, which EX writes to
//            HI and LO.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            signed_div_i      - 1 = DIV (signed), 0 = DIVU
//            opdata1_i         - dividend, sampled when the request is taken
//            opdata2_i         - divisor, sampled when the request is taken
//            start_i           - request, held by EX until it sees ready_o
//            annul_i           - abort an in-flight division
//            result_o          - {remainder, quotient}, registered
//            ready_o           - result valid, registered
// Options  : DIV_EARLY_OUT_EN  - when defined, a request with
//            |dividend| < |divisor| finishes in one cycle with quotient 0
//            and remainder = dividend.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    // BYZERO is also the one-cycle short-circuit state for early-out
    // requests; the preloaded partial remainder tells the two apart.
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BYZERO = 2'd1;
    localparam logic [1:0] c_ON     = 2'd2;
    localparam logic [1:0] c_END    = 2'd3;

    localparam logic [5:0] c_LAST_CNT = 6'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_d;

    logic [WIDTH-1:0]   r_dividend;   // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0]   r_divisor;    // divisor magnitude
    logic [WIDTH-1:0]   r_partial;    // partial remainder
    logic [WIDTH-1:0]   r_quot;       // quotient bits collected so far
    logic [5:0]         r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;

    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic [2*WIDTH-1:0] w_result_d;
    logic               w_ready_d;

    logic               w_accept;
    logic               w_abort;
    logic               w_div_zero;
    logic               w_early;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;

    logic [WIDTH:0]     w_shift;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_part_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // ------------------------------------------------------------------
    // Request decode and operand magnitudes
    // ------------------------------------------------------------------
    assign w_accept   = start_i & ~annul_i;
    assign w_abort    = annul_i | ~start_i;
    assign w_div_zero = (opdata2_i == '0);

    // 0x80..0 negates to itself, which is the correct unsigned magnitude.
    assign w_mag1 = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_mag2 = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = ~w_div_zero & (w_mag1 < w_mag2);
`else
    assign w_early = 1'b0;
`endif

    // ------------------------------------------------------------------
    // One restoring iteration: shift in the next dividend bit, trial
    // subtract. The shifted value needs W+1 bits, but after the subtract
    // (or restore) the remainder is below the divisor and fits in W bits,
    // so the low W bits of a modulo-2^W subtract are exact.
    // ------------------------------------------------------------------
    assign w_shift     = {r_partial, r_dividend[WIDTH-1]};
    assign w_borrow    = (w_shift < {1'b0, r_divisor});
    assign w_sub       = w_shift[WIDTH-1:0] - r_divisor;
    assign w_part_next = w_borrow ? w_shift[WIDTH-1:0] : w_sub;
    assign w_quot_next = {r_quot[WIDTH-2:0], ~w_borrow};

    // Sign fixup: quotient negative when signs differ, remainder follows
    // the dividend. Both flags are zero for unsigned requests.
    assign w_q_fix = r_neg_q ? -w_quot_next : w_quot_next;
    assign w_r_fix = r_neg_r ? -w_part_next : w_part_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_div_zero || w_early) begin
                        w_state_d = c_BYZERO;
                    end else begin
                        w_state_d = c_ON;
                    end
                end
            end
            c_BYZERO: begin
                w_state_d = c_END;
            end
            c_ON: begin
                if (w_abort) begin
                    w_state_d = c_IDLE;
                end else if (r_cnt == c_LAST_CNT) begin
                    w_state_d = c_END;
                end
            end
            c_END: begin
                // annul_i is deliberately ignored here; EX releases via start_i.
                if (!start_i) begin
                    w_state_d = c_IDLE;
                end
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values for the registered result/ready
    // ------------------------------------------------------------------
    always_comb begin
        w_result_d = r_result;
        w_ready_d  = r_ready;
        case (r_state)
            c_IDLE: begin
                w_result_d = '0;
                w_ready_d  = 1'b0;
            end
            c_BYZERO: begin
                // Divide-by-zero preloads zeros; early-out preloads the
                // original dividend as remainder.
                w_result_d = {r_partial, r_quot};
                w_ready_d  = 1'b1;
            end
            c_ON: begin
                if (!w_abort && (r_cnt == c_LAST_CNT)) begin
                    w_result_d = {w_r_fix, w_q_fix};
                    w_ready_d  = 1'b1;
                end else begin
                    w_result_d = '0;
                    w_ready_d  = 1'b0;
                end
            end
            c_END: begin
                if (!start_i) begin
                    w_result_d = '0;
                    w_ready_d  = 1'b0;
                end
            end
            default: begin
                w_result_d = '0;
                w_ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_result <= w_result_d;
            r_ready  <= w_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_partial  <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (w_accept) begin
                r_dividend <= w_mag1;
                r_divisor  <= w_mag2;
                r_partial  <= w_early ? opdata1_i : '0;
                r_quot     <= '0;
                r_cnt      <= '0;
                r_neg_q    <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                r_neg_r    <= signed_div_i & opdata1_i[WIDTH-1];
            end
        end else if (r_state == c_ON) begin
            r_partial  <= w_part_next;
            r_quot     <= w_quot_next;
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            r_cnt      <= r_cnt + 6'd1;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider. A table of directed
//            vectors with hand-computed results and latencies, followed by
//            hand-written sequences for abort, hold, reset and collision
//            corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp;
    int n_bad;

`ifdef DIV_EARLY_OUT_EN
    localparam int c_EO_LAT = 1;
`else
    localparam int c_EO_LAT = 32;
`endif

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    seq_divider #(.WIDTH(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Counts posedges from the next one (index 0) until ready_o is seen at
    // the following negedge; -1 if the bound expires. Returns at a negedge.
    task automatic wait_ready(input int max_edges, output int lat);
        lat = -1;
        for (int k = 0; k <= max_edges; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic drop_and_check(input string nm);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk64({nm, " ready after drop"}, {63'd0, ready_o}, 64'd0);
        chk64({nm, " result after drop"}, result_o, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        wait_ready(40, lat);
        chk_int({v.name, " latency"}, lat, v.lat);
        chk64({v.name, " result"}, result_o, v.exp);
        drop_and_check(v.name);
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{"u100/7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32};
        vecs[1]  = '{"s-7/2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 32};
        vecs[2]  = '{"s7/-2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32};
        vecs[3]  = '{"u5/0",     1'b0, 32'd5,          32'd0,          64'h00000000_00000000, 1};
        vecs[4]  = '{"sovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 32};
        vecs[5]  = '{"u9/3",     1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 32};
        vecs[6]  = '{"u3/10",    1'b0, 32'd3,          32'd10,         64'h00000003_00000000, c_EO_LAT};
        vecs[7]  = '{"uMAX/1",   1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 32};
        vecs[8]  = '{"s-100/7",  1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 32};
        vecs[9]  = '{"uMAX/16",  1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF, 32};
        vecs[10] = '{"s-3/10",   1'b1, 32'hFFFFFFFD,   32'd10,         64'hFFFFFFFD_00000000, c_EO_LAT};
        vecs[11] = '{"u7/7",     1'b0, 32'd7,          32'd7,          64'h00000000_00000001, 32};

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk64("reset ready", {63'd0, ready_o}, 64'd0);
        chk64("reset result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Annul at E10, then 9/3 accepted the following cycle; operands
        // are scrambled after its acceptance edge and must be ignored.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i   = 1'b0;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        chk64("annul ready", {63'd0, ready_o}, 64'd0);
        chk64("annul result", result_o, 64'd0);
        @(posedge clk);
        @(negedge clk);
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'd0;
        signed_div_i = 1'b1;
        wait_ready(40, lat);
        chk_int("after annul latency", lat, 31);
        chk64("after annul result", result_o, 64'h00000000_00000003);
        drop_and_check("after annul");

        // start_i dropped before E5 aborts; ready must never rise.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o === 1'b1) lat++;
        end
        chk_int("drop start ready cycles", lat, 0);

        // Hold start 3 cycles past ready; annul in END is ignored.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        wait_ready(40, lat);
        chk_int("hold latency", lat, 32);
        for (int k = 0; k < 3; k++) begin
            annul_i = (k == 1);
            @(posedge clk);
            @(negedge clk);
            chk64("hold ready", {63'd0, ready_o}, 64'd1);
            chk64("hold result", result_o, 64'h00000002_0000000E);
        end
        annul_i = 1'b0;
        drop_and_check("hold");

        // Reset at E15 discards the division.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk64("midrst ready", {63'd0, ready_o}, 64'd0);
        chk64("midrst result", result_o, 64'd0);
        rst = 1'b0;
        run_vec(vecs[5]);

        // start and annul together in IDLE are not accepted; acceptance
        // happens only once annul drops.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk64("collide ready", {63'd0, ready_o}, 64'd0);
        annul_i = 1'b0;
        wait_ready(40, lat);
        chk_int("collide latency", lat, 32);
        chk64("collide result", result_o, 64'h00000002_0000000E);
        drop_and_check("collide");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
